// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the FIFO drain serial transmitter
package fifo_pkg;

  localparam int DATO_WIDTH_DEF = 3;
  localparam int BIT_CYCLES_DEF = 4;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - per-bit down-counter; pulses o_bit_end on the last cycle of each serial bit
module bit_timer
  import fifo_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_bit_end
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == '0);
  assign o_bit_end = w_bit_end;

  // Reloads itself at the end of every bit so consecutive bits need no restart.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || w_bit_end) begin
      r_cnt <= LOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_drain_tx.sv
// rtl/fifo_drain_tx.sv - reads words from a FIFO and sends them LSB-first on a serial line; parity via FIFO_DRAIN_TX_PARITY_EN
module fifo_drain_tx
  import fifo_pkg::*;
#(
  parameter int DATO_WIDTH = DATO_WIDTH_DEF,
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  empy,
  input  logic [DATO_WIDTH-1:0] datin,
  output logic                  rd,
  output logic                  ser_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            word_cnt
);

  localparam int IW = $clog2(DATO_WIDTH + 1);
  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATO_WIDTH - 1);
  localparam logic [LW-1:0] LAST_WAIT = LW'(READ_LAT - 1);

  tx_state_t             r_state;
  logic [DATO_WIDTH-1:0] r_shift;
  logic                  r_parity;
  logic [IW-1:0]         r_bit_idx;
  logic [LW-1:0]         r_wait_cnt;
  logic                  r_rd;
  logic                  r_ser;
  logic                  r_busy;
  logic [7:0]            r_word_cnt;

  tx_state_t             w_next;
  logic [DATO_WIDTH-1:0] w_shift_nxt;
  logic                  w_parity_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic [LW-1:0]         w_wait_nxt;
  logic                  w_restart;
  logic                  w_frame_end;
  logic                  w_ser_nxt;
  logic                  w_go;
  logic                  w_bit_end;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_restart(w_restart),
    .o_bit_end(w_bit_end)
  );

  assign w_go = en & ~empy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_bit_idx  <= '0;
      r_wait_cnt <= '0;
      r_rd       <= 1'b0;
      r_ser      <= LINE_IDLE;
      r_busy     <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_rd       <= (w_next == ST_REQ);
      r_ser      <= w_ser_nxt;
      r_busy     <= (w_next != ST_IDLE);
      r_word_cnt <= r_word_cnt + {7'd0, w_frame_end};
    end
  end

  always_comb begin
    w_next       = r_state;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_idx_nxt    = r_bit_idx;
    w_wait_nxt   = r_wait_cnt;
    w_restart    = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) w_next = ST_REQ;
      end
      ST_REQ: begin
        w_wait_nxt = '0;
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        // Timer restarts here so the start bit gets a full BIT_CYCLES.
        if (r_wait_cnt == LAST_WAIT) begin
          w_shift_nxt  = datin;
          w_parity_nxt = ^datin;
          w_restart    = 1'b1;
          w_wait_nxt   = '0;
          w_next       = ST_START;
        end else begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_idx_nxt = '0;
          w_next    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == LAST_IDX) begin
            w_idx_nxt = '0;
`ifdef FIFO_DRAIN_TX_PARITY_EN
            w_next    = ST_PARITY;
`else
            w_next    = ST_STOP;
`endif
          end else begin
            w_idx_nxt   = r_bit_idx + 1'b1;
            w_shift_nxt = r_shift >> 1;
          end
        end
      end
`ifdef FIFO_DRAIN_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) w_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          w_frame_end = 1'b1;
          w_next      = w_go ? ST_REQ : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Line level is decided from the next state so ser_out stays a pure flop.
  always_comb begin
    w_ser_nxt = LINE_IDLE;
    case (w_next)
      ST_START:  w_ser_nxt = LINE_START;
      ST_DATA:   w_ser_nxt = w_shift_nxt[0];
      ST_PARITY: w_ser_nxt = w_parity_nxt;
      ST_STOP:   w_ser_nxt = LINE_STOP;
      default:   w_ser_nxt = LINE_IDLE;
    endcase
  end

  assign rd         = r_rd;
  assign ser_out    = r_ser;
  assign busy       = r_busy;
  assign frame_done = (r_state == ST_STOP) & w_bit_end;
  assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_fifo_drain_tx.sv
// tb/tb_fifo_drain_tx.sv - scoreboard bench for fifo_drain_tx with a behavioural FIFO and serial monitor
module tb_fifo_drain_tx;

  localparam int DW = 3;
  localparam int BC = 4;
  localparam int RL = 1;
`ifdef FIFO_DRAIN_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FL     = NBITS * BC;
  localparam int PERIOD = FL + RL + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [DW-1:0] datin = '0;
  logic          empy;
  logic          rd;
  logic          ser_out;
  logic          busy;
  logic          frame_done;
  logic [7:0]    word_cnt;

  always #5 clk = ~clk;

  fifo_drain_tx #(
    .DATO_WIDTH(DW),
    .BIT_CYCLES(BC),
    .READ_LAT  (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .empy      (empy),
    .datin     (datin),
    .rd        (rd),
    .ser_out   (ser_out),
    .busy      (busy),
    .frame_done(frame_done),
    .word_cnt  (word_cnt)
  );

  logic [DW-1:0] mem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  assign empy = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd && (wr_ptr != rd_ptr)) begin
      datin  <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w, input bit expect_frame);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
    if (expect_frame) exp_q.push_back(w);
  endtask

  function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
`ifdef FIFO_DRAIN_TX_PARITY_EN
    if (k == DW + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  int            cyc = 0;
  bit            mon_en = 1'b0;
  bit            rx_active = 1'b0;
  int            rx_cyc = 0;
  logic [DW-1:0] rx_word = '0;
  int            rd_cnt = 0;
  int            rd_times [$];
  int            frames_rx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      rx_active = 1'b0;
    end else begin
      if (rd) begin
        rd_cnt++;
        rd_times.push_back(cyc);
        check("rd_while_empty", empy, 0);
      end
      if (mon_en && !rx_active && ser_out == 1'b0) begin
        rx_active = 1'b1;
        rx_cyc    = 0;
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) rx_word = exp_q.pop_front();
      end
      if (rx_active) begin
        if (rx_cyc % BC == BC / 2) begin
          check("line_bit", ser_out, exp_bit(rx_word, rx_cyc / BC));
          check("busy_in_frame", busy, 1);
        end
        check("frame_done_pos", frame_done, rx_cyc == FL - 1);
        if (rx_cyc == FL - 1) begin
          rx_active = 1'b0;
          frames_rx++;
        end else begin
          rx_cyc++;
        end
      end else if (frame_done) begin
        check("frame_done_stray", frame_done, 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_wc(input logic [7:0] tgt, input int budget);
    int t = 0;
    while (word_cnt !== tgt && t < budget) begin
      tick();
      t++;
    end
    check("word_cnt_reach", word_cnt, tgt);
  endtask

  task automatic wait_rd(input int tgt, input int budget);
    int t = 0;
    while (rd_cnt < tgt && t < budget) begin
      tick();
      t++;
    end
    check("rd_reach", rd_cnt, tgt);
  endtask

  initial begin
    int base;
    int tbase;
    bit bad_ser;
    bit bad_busy;

    repeat (3) tick();
    check("rst_rd", rd, 0);
    check("rst_ser", ser_out, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_word_cnt", word_cnt, 0);
    rst = 1'b1;
    tick();

    // Frame aborted by reset in the middle of its data bits.
    base = rd_cnt;
    en = 1'b1;
    push_word(3'b110, 1'b0);
    wait_rd(base + 1, 20);
    repeat (RL + BC + 2) tick();
    check("abort_busy_before", busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_ser", ser_out, 1);
    check("abort_busy", busy, 0);
    check("abort_rd", rd, 0);
    check("abort_word_cnt", word_cnt, 0);
    repeat (10) tick();
    check("abort_no_retry_busy", busy, 0);
    check("abort_no_retry_rd", rd_cnt - base, 1);
    mon_en = 1'b1;

    // Empty FIFO with en high: nothing may happen.
    base = rd_cnt;
    bad_ser = 1'b0;
    bad_busy = 1'b0;
    repeat (100) begin
      tick();
      if (ser_out !== 1'b1) bad_ser = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    check("empty_rd", rd_cnt - base, 0);
    check("empty_ser_high", bad_ser, 0);
    check("empty_busy_low", bad_busy, 0);

    // Single word 3'b101.
    base = rd_cnt;
    push_word(3'b101, 1'b1);
    wait_wc(8'd1, FL + 40);
    check("single_rd_cnt", rd_cnt - base, 1);
    check("single_frames", frames_rx, 1);
    repeat (3) tick();
    check("single_idle_busy", busy, 0);

    // Five queued words back to back.
    base = rd_cnt;
    tbase = rd_times.size();
    for (int i = 0; i < 5; i++) push_word(DW'($urandom_range(0, (1 << DW) - 1)), 1'b1);
    wait_wc(8'd6, 5 * PERIOD + 40);
    check("burst_rd_cnt", rd_cnt - base, 5);
    for (int i = 1; i < 5; i++) begin
      if (rd_times.size() > tbase + i)
        check("burst_rd_spacing", rd_times[tbase+i] - rd_times[tbase+i-1], PERIOD);
    end
    check("burst_empy", empy, 1);
    repeat (3) tick();
    check("burst_idle_busy", busy, 0);

    // en dropped during the second of three frames.
    base = rd_cnt;
    for (int i = 0; i < 3; i++) push_word(DW'(i + 2), 1'b1);
    wait_rd(base + 2, 2 * PERIOD + 20);
    repeat (5) tick();
    en = 1'b0;
    wait_wc(8'd8, 2 * PERIOD + 40);
    repeat (60) tick();
    check("endrop_rd_cnt", rd_cnt - base, 2);
    check("endrop_busy", busy, 0);
    check("endrop_word_cnt", word_cnt, 8);
    en = 1'b1;
    wait_wc(8'd9, PERIOD + 40);
    check("resume_rd_cnt", rd_cnt - base, 3);

    repeat (5) tick();
    check("sb_drained", exp_q.size(), 0);
    check("frames_total", frames_rx, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
